dtc_vote_acc: RTL

DTC_VOTE_ACC -- requirements
Module: dtc_vote_acc

---
 rtl/dtc_pkg.sv | 15 +
 rtl/dtc_class_cnt.sv | 22 ++
 rtl/dtc_vote_acc.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dtc_pkg.sv
// Shared types and constants for the decision-tree class vote accumulator.
package dtc_pkg;

    typedef logic [2:0] class_t;

    localparam int NUM_CLASSES = 8;
    localparam int SCAN_CYCLES = 8;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/dtc_class_cnt.sv
// One per-class vote counter with synchronous clear and increment.
module dtc_class_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    // No saturation: the accumulator stops accepting once the window is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/dtc_vote_acc.sv
// Majority vote over a window of classifier results, with flush and output backpressure.
// Optional macro DTC_VOTE_CONF_EN drives out_conf with the winning count; otherwise it is 0.
module dtc_vote_acc
    import dtc_pkg::*;
#(
    parameter int WIN = 8,
    parameter int CW  = $clog2(WIN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [2:0]    in_class,
    output logic          in_ready,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_class,
    output logic [CW-1:0] out_conf,
    output logic [CW-1:0] out_n
);

    state_t                 state;
    state_t                 state_nxt;
    logic [3:0]             scan_idx;
    logic [NUM_CLASSES-1:0] cnt_inc;
    logic                   cnt_clr;
    logic                   accept;
    logic                   go_scan;
    logic [CW-1:0]          cnt_arr [NUM_CLASSES];
    logic [CW-1:0]          n;
    logic [CW-1:0]          best_cnt;
    class_t                 best_class;
    logic [CW-1:0]          scan_cnt;
    logic                   scan_last;

    assign accept    = (state == ACCUM) && in_valid;
    // A sample arriving together with flush is counted, so it makes n non-zero.
    assign go_scan   = (accept && (n == CW'(WIN - 1))) || (flush && ((n != '0) || in_valid));
    assign scan_cnt  = cnt_arr[scan_idx[2:0]];
    assign scan_last = (scan_idx == 4'(SCAN_CYCLES));
    assign out_valid = (state == HOLD);

    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cnt
        dtc_class_cnt #(.CW(CW)) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (cnt_clr),
            .inc (cnt_inc[i]),
            .cnt (cnt_arr[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ACCUM;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = '0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (accept)
                    cnt_inc[in_class] = 1'b1;
                if (go_scan)
                    state_nxt = SCAN;
            end
            SCAN: begin
                if (scan_last)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = ACCUM;
                    cnt_clr   = 1'b1;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Eight compare cycles, then one more cycle to register the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            scan_idx <= '0;
        else if (state != SCAN)
            scan_idx <= '0;
        else
            scan_idx <= scan_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            n <= '0;
        else if (cnt_clr)
            n <= '0;
        else if (accept)
            n <= n + 1'b1;
    end

    // Strictly-greater update keeps the lowest class index on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_class <= '0;
            best_cnt   <= '0;
        end else if (state == SCAN && !scan_last) begin
            if (scan_idx == 4'd0) begin
                best_class <= '0;
                best_cnt   <= scan_cnt;
            end else if (scan_cnt > best_cnt) begin
                best_class <= scan_idx[2:0];
                best_cnt   <= scan_cnt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_class <= '0;
            out_n     <= '0;
        end else if (state == SCAN && scan_last) begin
            out_class <= best_class;
            out_n     <= n;
        end
    end

`ifdef DTC_VOTE_CONF_EN
    logic [CW-1:0] conf_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conf_r <= '0;
        else if (state == SCAN && scan_last)
            conf_r <= best_cnt;
    end

    assign out_conf = conf_r;
`else
    assign out_conf = '0;
`endif

endmodule
